// File: rtl/mmio_pkg.sv
// mmio_pkg: shared widths, AFU register addresses and command type for the MMIO requester
package mmio_pkg;
  localparam int TID_W = 9;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;
  localparam logic [ADDR_W-1:0] AFU_DFH = 16'h0000;
  localparam logic [ADDR_W-1:0] AFU_ID_L = 16'h0002;
  localparam logic [ADDR_W-1:0] AFU_ID_H = 16'h0004;
  localparam logic [ADDR_W-1:0] USER_REG = 16'h0020;
  typedef struct packed {
    logic write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } t_mmio_cmd;
endpackage

// File: rtl/mmio_tid_table.sv
// mmio_tid_table: outstanding-read slots with generation-tagged TIDs, response matching and timeout detection
module mmio_tid_table import mmio_pkg::*; #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic alloc,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic rsp_valid,
  input  logic [TID_W-1:0] rsp_tid,
  input  logic to_en,
  output logic full,
  output logic [TID_W-1:0] alloc_tid,
  output logic match,
  output logic [ADDR_W-1:0] match_addr,
  output logic to_fire,
  output logic [ADDR_W-1:0] to_addr
);
  localparam int SLOT_W = $clog2(MAX_OUTSTANDING);
  localparam int GEN_W = TID_W - SLOT_W;
  localparam int AGE_W = $clog2(TIMEOUT);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT - 1);
  logic [MAX_OUTSTANDING-1:0] busy;
  logic [ADDR_W-1:0] addr_q [MAX_OUTSTANDING];
  logic [GEN_W-1:0] gen_q [MAX_OUTSTANDING];
  logic [AGE_W-1:0] age_q [MAX_OUTSTANDING];
  logic [SLOT_W-1:0] free_s, to_s, rsp_s;
  logic to_any;
  assign rsp_s = rsp_tid[SLOT_W-1:0];
  assign full = &busy;
  assign match = rsp_valid && busy[rsp_s] && gen_q[rsp_s] == rsp_tid[TID_W-1:SLOT_W];
  assign match_addr = addr_q[rsp_s];
  assign alloc_tid = {gen_q[free_s], free_s};
  assign to_fire = to_en && to_any;
  assign to_addr = addr_q[to_s];
  // Descending scan so the lowest index wins; a slot answered this cycle never times out.
  always_comb begin
    free_s = '0;
    to_s = '0;
    to_any = 1'b0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!busy[i]) free_s = SLOT_W'(i);
      if (busy[i] && age_q[i] == AGE_MAX && !(match && rsp_s == SLOT_W'(i))) begin
        to_s = SLOT_W'(i);
        to_any = 1'b1;
      end
    end
  end
  // Age saturates at AGE_MAX so a timeout that loses arbitration stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        addr_q[i] <= '0;
        gen_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if ((match && rsp_s == SLOT_W'(i)) || (to_fire && to_s == SLOT_W'(i))) begin
          busy[i] <= 1'b0;
          gen_q[i] <= gen_q[i] + GEN_W'(1);
        end else if (alloc && free_s == SLOT_W'(i)) begin
          busy[i] <= 1'b1;
          addr_q[i] <= alloc_addr;
          age_q[i] <= '0;
        end else if (busy[i] && age_q[i] != AGE_MAX) begin
          age_q[i] <= age_q[i] + AGE_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/mmio_requester.sv
// mmio_requester: issues CCI-P MMIO read/write requests to an AFU and reports read completions.
// One completion per cycle: misaligned error > held response > new response > timeout.
module mmio_requester import mmio_pkg::*; #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [63:0] cmd_wdata,
  output logic mmio_wr_valid,
  output logic mmio_rd_valid,
  output logic [15:0] mmio_addr,
  output logic [8:0] mmio_tid,
  output logic [63:0] mmio_wdata,
  input  logic rsp_valid,
  input  logic [8:0] rsp_tid,
  input  logic [63:0] rsp_data,
  output logic wr_ack,
  output logic rd_done,
  output logic [15:0] rd_addr,
  output logic [63:0] rd_data,
  output logic rd_err,
  output logic [15:0] stray_cnt
);
  t_mmio_cmd cmd;
  logic full, match, to_fire, to_en, acc, mis, rd_ok, wr_ok, hold_v, done;
  logic [TID_W-1:0] alloc_tid;
  logic [ADDR_W-1:0] match_addr, to_addr, hold_addr;
  logic [DATA_W-1:0] hold_data;
  assign cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  // A response displaced by a misaligned error is parked; commands pause while it drains.
  assign cmd_ready = !full && !hold_v;
  assign acc = cmd_valid && cmd_ready;
  assign mis = acc && cmd.addr[0];
  assign wr_ok = acc && cmd.write && !cmd.addr[0];
  assign rd_ok = acc && !cmd.write && !cmd.addr[0];
  assign to_en = !mis && !hold_v && !match;
  assign done = mis || hold_v || match || to_fire;
  mmio_tid_table #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .TIMEOUT(TIMEOUT)) u_table (
    .clk(clk),
    .rst_n(rst_n),
    .alloc(rd_ok),
    .alloc_addr(cmd.addr),
    .rsp_valid(rsp_valid),
    .rsp_tid(rsp_tid),
    .to_en(to_en),
    .full(full),
    .alloc_tid(alloc_tid),
    .match(match),
    .match_addr(match_addr),
    .to_fire(to_fire),
    .to_addr(to_addr)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmio_wr_valid <= 1'b0;
      mmio_rd_valid <= 1'b0;
      mmio_addr <= '0;
      mmio_tid <= '0;
      mmio_wdata <= '0;
      wr_ack <= 1'b0;
      rd_done <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
      rd_err <= 1'b0;
      stray_cnt <= '0;
      hold_v <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      mmio_wr_valid <= wr_ok;
      mmio_rd_valid <= rd_ok;
      wr_ack <= wr_ok;
      if (wr_ok || rd_ok) begin
        mmio_addr <= cmd.addr;
        mmio_tid <= cmd.write ? '0 : alloc_tid;
        mmio_wdata <= cmd.wdata;
      end
      rd_done <= done;
      rd_err <= mis || to_fire;
      if (done) begin
        rd_addr <= mis ? cmd.addr : hold_v ? hold_addr : match ? match_addr : to_addr;
        rd_data <= mis ? '0 : hold_v ? hold_data : match ? rsp_data : '0;
      end
      hold_v <= match && (mis || hold_v);
      if (match) begin
        hold_addr <= match_addr;
        hold_data <= rsp_data;
      end
      if (rsp_valid && !match && stray_cnt != 16'hFFFF) stray_cnt <= stray_cnt + 16'd1;
    end
  end
endmodule

// File: doc/mmio_requester.md
Name: mmio_requester

Overview:
- Initiator side of the CCI-P MMIO channel: accepts simple read/write commands and issues MMIO requests toward an AFU's c0 MMIO inputs.
- Matches the AFU's c2 read responses back to requests by TID and reports completions.
- Used as a synthesizable on-chip host stand-in for AFU loopback and self-test, e.g. exercising the user register at 0x0020.

Parameters:
- MAX_OUTSTANDING, 4: read slots in flight; power of 2, range 2..16.
- TIMEOUT, 1024: cycles a read may remain outstanding before error completion; must be ≥ 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  16  MMIO address, 32-bit word units
- cmd_wdata  in  64  write data
- mmio_wr_valid  out  1  write request strobe (to AFU rx.c0.mmioWrValid)
- mmio_rd_valid  out  1  read request strobe (to AFU rx.c0.mmioRdValid)
- mmio_addr  out  16  request address
- mmio_tid  out  9  request TID
- mmio_wdata  out  64  request data
- rsp_valid  in  1  AFU read response (tx.c2.mmioRdValid)
- rsp_tid  in  9  response TID
- rsp_data  in  64  response data
- wr_ack  out  1  one-cycle pulse, write issued
- rd_done  out  1  one-cycle pulse, read completed
- rd_addr  out  16  address of completed read
- rd_data  out  64  read data; 0 on error
- rd_err  out  1  timeout or misaligned
- stray_cnt  out  16  count of unmatched responses; saturates at 0xFFFF

Behaviour:
- Reset (async assert, sync deassert): all strobes 0; mmio_addr, mmio_tid, mmio_wdata, rd_addr, rd_data = 0; rd_err = 0; stray_cnt = 0; all slots free; all generation counters 0.
- Outputs are registered. A command accepted in cycle N drives mmio_* in cycle N+1.
- Only one request is issued per cycle. A write and a read strobe are never asserted together.
- cmd_ready = 1 when at least one slot is free. It is deasserted when the slot table is full, for writes too.
- Write: mmio_wr_valid = 1 for one cycle with addr and wdata; mmio_tid = 0. wr_ack pulses in the same cycle. No slot is consumed.
- Read:
  - Allocate the lowest-index free slot s.
  - TID = {generation[s] (9 − log2(MAX_OUTSTANDING) bits), s}.
  - Store addr; clear the age counter.
  - Assert mmio_rd_valid = 1 for one cycle.
- Misaligned 64-bit access (cmd_addr[0] = 1): the command is accepted but no bus request is issued.
  - A read produces rd_done = 1, rd_err = 1, rd_data = 0 in cycle N+1.
  - A write produces wr_ack = 0 and rd_done = 1, rd_err = 1, rd_addr = cmd_addr.
- Response matching: rsp_valid with slot field busy and a matching generation:
  - rd_done = 1 next cycle, with rd_data = rsp_data, rd_addr = stored addr, rd_err = 0.
  - The slot is freed and generation[s] increments, wrapping.
- A response that does not match (free slot or stale generation) is dropped and stray_cnt increments.
- Completions may arrive out of order; each is reported as it arrives.
- Timeout: each busy slot's age increments every cycle. When age reaches TIMEOUT − 1:
  - rd_done = 1, rd_err = 1, rd_data = 0.
  - The slot is freed and its generation increments.
- Arbitration for rd_done (one completion per cycle). Priority: misaligned error > response > timeout (lowest slot first).
  - A deferred timeout holds its age saturated and fires on the next available cycle.
- Response and timeout on the same slot in the same cycle: the response wins and no timeout is reported.
- A slot freed in cycle N is allocatable in cycle N+1. A response in the same cycle as a new read allocation is both handled.
- Reset mid-operation: all pending reads are discarded with no completion reported. Post-reset responses count as stray.

Decomposition:
- Shared package mmio_pkg, containing:
  - TID_W = 9, ADDR_W = 16, DATA_W = 64.
  - Address constants: AFU_DFH = 16'h0000, AFU_ID_L = 16'h0002, AFU_ID_H = 16'h0004, USER_REG = 16'h0020.
  - typedef t_mmio_cmd {write, addr, wdata}.
- Sub-module mmio_tid_table: slot valid/addr/generation/age storage, free-slot priority encoder, match and timeout detection.
- The top level holds command acceptance, the request register, completion arbitration and stray_cnt.

Test Plan:
- Read 0x0000 with the AFU attached: rd_done, rd_data = 64'h1000_0100_0000_0000, rd_err = 0, rd_addr = 0x0000.
- Write 0x0020 with 64'hDEAD_BEEF_0123_4567, then read 0x0020: wr_ack on the issue cycle; read returns the same value (AFU FIFO latency respected).
- Issue 4 reads with the responder returning TIDs in order 3, 1, 0, 2:
  - Four rd_done pulses in that order with correct addresses.
  - cmd_ready = 0 after the 4th read until the first completion.
- Silent responder, TIMEOUT = 16: rd_done with rd_err = 1, rd_data = 0 exactly 16 cycles after mmio_rd_valid. A late response with the old TID increments stray_cnt to 1.
- cmd_addr = 0x0021 read: no mmio_rd_valid; rd_done with rd_err = 1 in the next cycle.
- Assert rst_n = 0 with 2 reads outstanding: outputs clear immediately. Subsequent responses give stray_cnt = 2 and no rd_done.
